// File: rtl/div_sequencer.sv
// div_sequencer: iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// A 32-step restoring divider with a one-cycle sign/fast-path setup and a
// one-cycle sign fixup. It holds the pipeline through `stall` until the
// registered result_valid pulse.
//
// Handshake: an op is taken on a clock edge where state is IDLE, start=1,
// funct3[2]=1 and flush=0. stall is high from that cycle until the cycle
// before result_valid. result_valid is a one-cycle pulse in DONE, and the
// pipeline advances in that same cycle. A start seen while busy is dropped.
module div_sequencer #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [2:0]      dbg_state
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2:0]        f3_q, f3_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   div_q, div_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d;

    logic              is_signed;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN:0]     shift_w;
    logic [XLEN:0]     trial_w;

    // Next-state and datapath computation for every register.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        f3_d      = f3_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        valid_d   = 1'b0;

        is_signed = ~f3_q[0];
        abs_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
        abs_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
        // {rem, quo} shifted left by one; the top bit of rem survives in the
        // extra bit so the trial subtract sees the full partial remainder.
        shift_w   = {rem_q, quo_q[XLEN-1]};
        trial_w   = shift_w - {1'b0, div_q};

        case (state_q)
            S_IDLE: begin
                if (start && funct3[2] && !flush) begin
                    a_d     = operand_a;
                    b_d     = operand_b;
                    f3_d    = funct3;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                neg_quo_d = is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
                neg_rem_d = is_signed & a_q[XLEN-1];
                quo_d     = abs_a;
                div_d     = abs_b;
                rem_d     = '0;
                cnt_d     = CNT_W'(ITER - 1);
                if (b_q == '0) begin
                    // Divide by zero: quotient all ones, remainder is raw a.
                    result_d = f3_q[1] ? a_q : '1;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else if (is_signed && a_q == MOST_NEG && b_q == '1) begin
                    // Signed overflow: quotient wraps to MOST_NEG, remainder 0.
                    result_d = f3_q[1] ? '0 : MOST_NEG;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (!trial_w[XLEN]) begin
                    rem_d = trial_w[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = shift_w[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                if (f3_q[1]) begin
                    result_d = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    result_d = neg_quo_q ? -quo_q : quo_q;
                end
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An aborted op leaves no trace on the result port.
        if (flush && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            f3_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            f3_q      <= f3_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign stall        = (state_q == S_IDLE && start && funct3[2]) ||
                          (state_q == S_SETUP) || (state_q == S_ITER) ||
                          (state_q == S_FIXUP);
    assign result_valid = valid_q;
    assign result       = result_q;
    assign dbg_state    = state_q;

endmodule
